transmissor_status_elevador: RTL and testbench

TRANSMISSOR_STATUS_ELEVADOR -- requirements
Module: transmissor_status_elevador

---
 rtl/transmissor_status_elevador_if.sv | 28 ++
 rtl/transmissor_status_elevador.sv | 151 +++++++++++++++
 tb/tb_transmissor_status_elevador.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/transmissor_status_elevador_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// transmissor_status_elevador_if: request, contents-RAM and serial/status bus
// of the elevator status transmitter.  Rev 1.0
// ----------------------------------------------------------------------------
interface transmissor_status_elevador_if;
    logic       partida;
    logic [1:0] andar_atual;
    logic [4:0] n_itens;
    logic [3:0] item_addr;
    logic [1:0] item_tipo;
    logic [1:0] item_destino;
    logic       TX;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    modport master (
        output partida, andar_atual, n_itens, item_tipo, item_destino,
        input  item_addr, TX, ocupado, pronto, db_estado
    );

    modport slave (
        input  partida, andar_atual, n_itens, item_tipo, item_destino,
        output item_addr, TX, ocupado, pronto, db_estado
    );
endinterface
`default_nettype wire

// File: rtl/transmissor_status_elevador.sv
`default_nettype none
// ----------------------------------------------------------------------------
// transmissor_status_elevador: sends one 8N1 status frame (sync, count/floor,
// items, terminator) per accepted request.  Rev 1.0
// ----------------------------------------------------------------------------
module transmissor_status_elevador #(
    parameter int BAUD_DIV = 434
) (
    input  wire logic clock,
    input  wire logic reset,
    transmissor_status_elevador_if.slave bus
);
    localparam logic [15:0] C_BAUD_LAST = 16'(BAUD_DIV - 1);
    // Third-to-last clock of a byte: the RAM fetch then fills the final two stop-bit clocks.
    localparam logic [15:0] C_PRE_BAUD  = (BAUD_DIV >= 3) ? 16'(BAUD_DIV - 3) : 16'(BAUD_DIV - 1);
    localparam logic [3:0]  C_PRE_BIT   = (BAUD_DIV >= 3) ? 4'd9 : 4'd8;
    localparam logic [7:0]  C_SYNC      = 8'hA5;
    localparam logic [7:0]  C_TERM      = 8'h0A;

    typedef enum logic [3:0] {
        OCIOSO     = 4'd0,
        CABECALHO  = 4'd1,
        CONTAGEM   = 4'd2,
        LE_ITEM    = 4'd3,
        ESPERA_RAM = 4'd4,
        ITEM       = 4'd5,
        TERMINADOR = 4'd6,
        FIM        = 4'd7
    } estado_t;

    estado_t     r_state;
    estado_t     w_next;
    logic [15:0] r_baud;
    logic [3:0]  r_bit;
    logic [7:0]  r_byte;
    logic [4:0]  r_n_lat;
    logic [1:0]  r_andar;
    logic [3:0]  r_addr;

    logic        w_sending;
    logic        w_byte_end;
    logic        w_pre_end;
    logic        w_more;
    logic [4:0]  w_n_clamp;
    logic [3:0]  w_bit_m1;
    logic        w_tx;

    assign w_sending  = (r_state != OCIOSO) && (r_state != FIM);
    assign w_byte_end = w_sending && (r_bit == 4'd9) && (r_baud == C_BAUD_LAST);
    assign w_pre_end  = w_sending && (r_bit == C_PRE_BIT) && (r_baud == C_PRE_BAUD);
    assign w_more     = ({1'b0, r_addr} + 5'd1) < r_n_lat;
    assign w_n_clamp  = (bus.n_itens > 5'd16) ? 5'd16 : bus.n_itens;
    assign w_bit_m1   = r_bit - 4'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= OCIOSO;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_tx   = 1'b1;
        case (r_state)
            OCIOSO:     if (bus.partida) w_next = CABECALHO;
            CABECALHO:  if (w_byte_end) w_next = CONTAGEM;
            CONTAGEM: begin
                if (r_n_lat != 5'd0) begin
                    if (w_pre_end) w_next = LE_ITEM;
                end else if (w_byte_end) begin
                    w_next = TERMINADOR;
                end
            end
            LE_ITEM:    w_next = ESPERA_RAM;
            ESPERA_RAM: w_next = ITEM;
            ITEM: begin
                if (w_more) begin
                    if (w_pre_end) w_next = LE_ITEM;
                end else if (w_byte_end) begin
                    w_next = TERMINADOR;
                end
            end
            TERMINADOR: if (w_byte_end) w_next = FIM;
            FIM:        w_next = OCIOSO;
            default:    w_next = OCIOSO;
        endcase

        if (w_sending) begin
            case (r_bit)
                4'd0:    w_tx = 1'b0;
                4'd9:    w_tx = 1'b1;
                default: w_tx = r_byte[w_bit_m1[2:0]];
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_n_lat <= '0;
            r_andar <= '0;
            r_addr  <= '0;
        end else begin
            if (w_sending) begin
                if (r_baud == C_BAUD_LAST) begin
                    r_baud <= '0;
                    r_bit  <= (r_bit == 4'd9) ? 4'd0 : r_bit + 4'd1;
                end else begin
                    r_baud <= r_baud + 16'd1;
                end
            end else begin
                r_baud <= '0;
                r_bit  <= '0;
            end

            case (r_state)
                OCIOSO: begin
                    if (w_next == CABECALHO) begin
                        r_n_lat <= w_n_clamp;
                        r_andar <= bus.andar_atual;
                        r_byte  <= C_SYNC;
                        r_addr  <= '0;
                    end
                end
                CABECALHO:  if (w_next == CONTAGEM) r_byte <= {1'b0, r_n_lat, r_andar};
                // Stop bit is constant 1, so the next byte can be loaded while it is still on the line.
                ESPERA_RAM: r_byte <= {4'h3, bus.item_tipo, bus.item_destino};
                default:    ;
            endcase

            if ((w_next == TERMINADOR) && (r_state != TERMINADOR)) begin
                r_byte <= C_TERM;
                r_addr <= '0;
            end
            if ((r_state == ITEM) && (w_next == LE_ITEM)) begin
                r_addr <= r_addr + 4'd1;
            end
        end
    end

    assign bus.TX        = w_tx;
    assign bus.ocupado   = (r_state != OCIOSO);
    assign bus.pronto    = (r_state == FIM);
    assign bus.db_estado = r_state;
    assign bus.item_addr = r_addr;
endmodule
`default_nettype wire

// File: tb/tb_transmissor_status_elevador.sv
`default_nettype none
// tb_transmissor_status_elevador: randomized status frames compared cycle by
// cycle against a byte-list reference model of the serial line.
module tb_transmissor_status_elevador;
    localparam int B        = 4;
    localparam int BYTE_CLK = 10 * B;
    typedef byte unsigned bq_t[$];

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    transmissor_status_elevador_if bus();
    transmissor_status_elevador #(.BAUD_DIV(B)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Contents RAM: synchronous read, data one clock after the address.
    logic [3:0] mem [16];
    always @(posedge clock) {bus.item_tipo, bus.item_destino} <= mem[bus.item_addr];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bq_t build(input logic [1:0] a, input logic [4:0] n);
        bq_t q;
        int  nl;
        nl = (int'(n) > 16) ? 16 : int'(n);
        q.push_back(8'hA5);
        q.push_back(8'(nl * 4 + int'(a)));
        for (int i = 0; i < nl; i++) q.push_back(8'(8'h30 + mem[i]));
        q.push_back(8'h0A);
        return q;
    endfunction

    // Reference model: frame as a list of bytes plus a clock index into it.
    bit  m_busy = 0;
    int  m_cyc, m_total, m_n;
    bq_t m_bytes;

    initial forever begin
        @(posedge clock or negedge reset);
        if (!reset) m_busy = 0;
        else if (m_busy) begin
            if (m_cyc == m_total) m_busy = 0;
            else m_cyc++;
        end else if (bus.partida) begin
            m_bytes = build(bus.andar_atual, bus.n_itens);
            m_n     = m_bytes.size() - 3;
            m_total = m_bytes.size() * BYTE_CLK;
            m_cyc   = 0;
            m_busy  = 1;
        end
    end

    function automatic int exp_tx();
        int k, b;
        byte unsigned v;
        if (!m_busy || m_cyc >= m_total) return 1;
        k = m_cyc / BYTE_CLK;
        b = (m_cyc % BYTE_CLK) / B;
        if (b == 0) return 0;
        if (b == 9) return 1;
        v = m_bytes[k];
        return (int'(v) >> (b - 1)) & 1;
    endfunction

    function automatic int exp_state();
        int k, pos;
        if (!m_busy) return 0;
        if (m_cyc == m_total) return 7;
        k   = m_cyc / BYTE_CLK;
        pos = m_cyc % BYTE_CLK;
        if (k == 0) return 1;
        if (k == m_n + 2) return 6;
        if (k <= m_n && pos == BYTE_CLK - 2) return 3;
        if (k <= m_n && pos == BYTE_CLK - 1) return 4;
        return (k == 1) ? 2 : 5;
    endfunction

    initial forever begin
        int st;
        @(posedge clock);
        #1;
        st = exp_state();
        chk("tx", int'(bus.TX), exp_tx());
        chk("ocupado", int'(bus.ocupado), int'(m_busy));
        chk("pronto", int'(bus.pronto), int'(m_busy && m_cyc == m_total));
        chk("db_estado", int'(bus.db_estado), st);
        if (st == 3 || st == 4) chk("item_addr_fetch", int'(bus.item_addr), m_cyc / BYTE_CLK - 1);
        else if (!m_busy) chk("item_addr_idle", int'(bus.item_addr), 0);
    end

    task automatic chk_frame(input string name, input bq_t got, input bq_t exp);
        chk({name, "_size"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk({name, "_byte"}, int'(got[i]), int'(exp[i]));
    endtask

    task automatic run_frame(input logic [1:0] a, input logic [4:0] n, input bit noise, output int len);
        int t;
        @(negedge clock);
        bus.andar_atual = a;
        bus.n_itens     = n;
        bus.partida     = 1'b1;
        @(negedge clock);
        bus.partida = 1'b0;
        chk("accept", int'(bus.ocupado), 1);
        t = 0;
        while (!bus.pronto && t < 2000) begin
            @(negedge clock);
            t++;
            if (noise) begin
                bus.partida     = 1'($urandom);
                bus.andar_atual = 2'($urandom);
                bus.n_itens     = 5'($urandom);
            end
        end
        if (!bus.pronto) chk("pronto_timeout", int'(bus.pronto), 1);
        len = t;
        bus.partida = 1'b1;
        @(negedge clock);
        bus.partida = 1'b0;
        chk("fim_ignores_partida", int'(bus.ocupado), 0);
    endtask

    initial begin
        int  len, nn;
        bq_t q, e;
        logic [1:0] a;
        logic [4:0] n;

        bus.partida     = 1'b0;
        bus.andar_atual = 2'd0;
        bus.n_itens     = 5'd0;
        foreach (mem[i]) mem[i] = 4'd0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_tx", int'(bus.TX), 1);
        chk("rst_ocupado", int'(bus.ocupado), 0);
        chk("rst_pronto", int'(bus.pronto), 0);
        chk("rst_db_estado", int'(bus.db_estado), 0);
        chk("rst_item_addr", int'(bus.item_addr), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Empty frame
        q = build(2'd2, 5'd0);
        e = '{8'hA5, 8'h02, 8'h0A};
        chk_frame("model_n0", q, e);
        run_frame(2'd2, 5'd0, 1'b0, len);
        chk("len_n0", len, 120);

        // Three items
        mem[0] = 4'b0110;
        mem[1] = 4'b1011;
        mem[2] = 4'b1100;
        q = build(2'd2, 5'd3);
        e = '{8'hA5, 8'h0E, 8'h36, 8'h3B, 8'h3C, 8'h0A};
        chk_frame("model_n3", q, e);
        run_frame(2'd2, 5'd3, 1'b0, len);
        chk("len_n3", len, 240);

        // Clamped count
        foreach (mem[i]) mem[i] = 4'($urandom);
        q = build(2'd0, 5'd20);
        chk("model_n20_size", q.size(), 19);
        chk("model_n20_hdr", int'(q[1]), 8'h40);
        run_frame(2'd0, 5'd20, 1'b0, len);
        chk("len_n20", len, 760);

        // Requests and input changes while busy
        run_frame(2'd1, 5'd5, 1'b1, len);
        chk("len_noise", len, 320);

        // Reset during data bit 4 of the second item byte
        @(negedge clock);
        bus.andar_atual = 2'd1;
        bus.n_itens     = 5'd3;
        bus.partida     = 1'b1;
        @(negedge clock);
        bus.partida = 1'b0;
        repeat (3 * BYTE_CLK + 5 * B + 1) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("abort_tx", int'(bus.TX), 1);
        chk("abort_ocupado", int'(bus.ocupado), 0);
        chk("abort_pronto", int'(bus.pronto), 0);
        chk("abort_db_estado", int'(bus.db_estado), 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("after_abort_idle", int'(bus.ocupado), 0);
        run_frame(2'd3, 5'd2, 1'b0, len);
        chk("len_after_abort", len, 200);

        // Random frames
        for (int f = 0; f < 12; f++) begin
            foreach (mem[i]) mem[i] = 4'($urandom);
            a  = 2'($urandom);
            n  = 5'($urandom_range(0, 31));
            nn = (int'(n) > 16) ? 16 : int'(n);
            run_frame(a, n, 1'b1, len);
            chk("len_rand", len, (3 + nn) * BYTE_CLK);
            repeat ($urandom_range(0, 5)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
